pwm_gate_guard: RTL and testbench
=================================

# pwm_gate_guard

Hardware gate-drive safety stage between the SoC PWM outputs and the H-bridge gate-driver pins of the 5-level inverter. It re-registers the eight PWM requests in the 100 MHz domain, enforces a minimum dead time between complementary switches of each leg, and latches a fault and blanks the leg on any shoot-through request. It also blanks all gates on emergency stop. It runs on the raw board oscillator and is fully independent of CPU firmware.

## Interface
- DT_MIN, 50, dead time in clk_100mhz cycles (500 ns); legal range 1..255; 8-bit counter
- clk_100mhz  in  1  board oscillator, sole clock
- rst_n  in  1  reset, asynchronous, active-low
- pwm_in  in  8  gate requests from the SoC; leg k: bit 2k = high side, bit 2k+1 = low side; asynchronous to this block
- estop_n  in  1  emergency stop, active low, asynchronous
- fault_clr  in  1  single-cycle clear pulse, synchronous to clk_100mhz
- gate_out  out  8  gate-driver drive, same bit map as pwm_in, registered
- leg_fault  out  4  latched shoot-through fault per leg, registered
- estop_latched  out  1  latched emergency stop, registered
- gate_ok  out  1  registered; equals ~estop_latched & ~|leg_fault

## Operation
- Synchronizers:
  - pwm_in passes through two flops (reset 0).
  - estop_n passes through two flops (reset 1, inactive).
  - FSMs and latches use only the second-stage values (req, est).
- One identical FSM per leg, with an 8-bit dead counter. req = {low,high} of that leg.
- IDLE (gates off):
  - req 01 -> HI.
  - req 10 -> LO.
  - req 11 -> FAULT.
  - req 00 -> stay.
- HI (high gate on):
  - req 01 -> stay.
  - req 11 -> FAULT.
  - otherwise -> DEAD with cnt = DT_MIN-1.
- LO: symmetric to HI (high and low swapped).
- DEAD (gates off):
  - cnt != 0 -> decrement.
  - cnt == 0 -> evaluate req exactly as IDLE does.
  - Result: the gap between one gate turning off and either gate turning on is ≥ DT_MIN cycles. A same-side re-assert also waits.
- FAULT (gates off, leg_fault[k] = 1):
  - fault_clr with req == 00 -> IDLE, and leg_fault[k] is cleared.
  - fault_clr with req != 00 is ignored.
- gate_out high bit = (next state == HI); gate_out low bit = (next state == LO). Both are registered, so the two bits of a leg are never high together.
- Emergency stop:
  - est == 0 sets estop_latched.
  - While est == 0 or estop_latched == 1:
    - All gate_out are 0.
    - Every non-FAULT leg FSM is forced to IDLE and its counter cleared.
    - FAULT legs keep their fault.
  - fault_clr clears estop_latched only when est == 1.
  - If est == 0 and fault_clr arrive in the same cycle, the stop wins and the latch stays set.
  - Leaving estop returns legs to IDLE. No dead time is inserted, because the gates have already been off ≥ 1 cycle.
- A single fault_clr pulse may clear estop_latched and all clearable legs in the same cycle.

## Timing
- Reset values:
  - gate_out = 0, leg_fault = 0, estop_latched = 0, gate_ok = 0.
  - All FSMs in IDLE, counters 0.
- gate_ok becomes 1 on the first edge after reset release if no fault is present.
- Latency, pwm_in change to gate_out: 3 edges (sync1, sync2, state/output register).
- Latency, estop_n fall to gate_out = 0 and estop_latched = 1: 3 edges.
- Shoot-through request to leg_fault set and gates low: 3 edges.
- gate_ok follows leg_fault / estop_latched with 1 extra cycle (4 edges from input).
- Dead-time gap: with DT_MIN = N and a direct 01 -> 10 switch, gate_out shows exactly N cycles of 00 between the two on-phases.
- Input glitches shorter than one clk_100mhz period may be missed. This is acceptable: the requests come from a 50 MHz source and are ≥ 2 cycles wide.
- Reset mid-operation: all gates drop asynchronously the instant rst_n falls.

## Test plan
- Reset: hold rst_n low with pwm_in = 0xFF and estop_n = 0 -> all outputs 0. Release with pwm_in = 0 and estop_n = 1 -> gate_ok = 1 one edge later, gate_out = 0x00.
- Dead time (DT_MIN = 50):
  - pwm_in = 0x01 -> gate_out = 0x01 after 3 edges.
  - Then pwm_in = 0x02 -> gate_out = 0x00 for exactly 50 cycles, then 0x02.
- Shoot-through:
  - pwm_in = 0x0C -> after 3 edges, leg_fault = 0b0010 and gate_out[3:2] = 00; next edge gate_ok = 0. Leg 0 is unaffected.
  - fault_clr while pwm_in = 0x0C -> ignored.
  - pwm_in = 0x00 then fault_clr -> leg_fault = 0.
- Estop:
  - pwm_in = 0x55, estop_n low -> gate_out = 0x00 and estop_latched = 1 within 3 edges.
  - estop_n high -> latch stays.
  - fault_clr -> latch clears; gate_out = 0x55 two edges after the clear.
- Simultaneous events: estop_n low (synchronized) in the same cycle as fault_clr -> estop_latched remains 1.
- Short re-assert: high request 01 -> 00 for 2 cycles -> 01 -> high gate off for exactly DT_MIN cycles before re-asserting.

Source files
------------

// File: rtl/pwm_gate_guard_if.sv
// pwm_gate_guard_if: PWM request / gate drive / fault status bundle for pwm_gate_guard
//   pwm_in[7:0]   SoC gate requests, leg k: bit 2k high side, bit 2k+1 low side (async)
//   estop_n       emergency stop, active low (async)
//   fault_clr     single-cycle clear pulse, synchronous to clk_100mhz
//   gate_out[7:0] gate-driver drive, same bit map as pwm_in
//   leg_fault[3:0], estop_latched, gate_ok  latched status
interface pwm_gate_guard_if;
   logic [7:0] pwm_in;
   logic       estop_n;
   logic       fault_clr;
   logic [7:0] gate_out;
   logic [3:0] leg_fault;
   logic       estop_latched;
   logic       gate_ok;
   modport master (output pwm_in, estop_n, fault_clr, input gate_out, leg_fault, estop_latched, gate_ok);
   modport slave (input pwm_in, estop_n, fault_clr, output gate_out, leg_fault, estop_latched, gate_ok);
endinterface

// File: rtl/pwm_gate_guard.sv
// pwm_gate_guard: dead-time, shoot-through and estop guard between SoC PWM and H-bridge gates
//   clk_100mhz  board oscillator, sole clock
//   rst_n       asynchronous active-low reset, drops all gates immediately
//   bus         pwm_gate_guard_if.slave (requests in, gate drive and fault status out)
module pwm_gate_guard #(
   parameter int DT_MIN = 50
) (
   input logic               clk_100mhz,
   input logic               rst_n,
   pwm_gate_guard_if.slave   bus
);
   typedef enum logic [2:0] {IDLE, HI, LO, DEAD, FAULT} state_t;
   localparam logic [7:0] DT_LD = 8'(DT_MIN - 1);
   logic [7:0] pwm_s1, req, gate_q;
   logic       est_s1, est, est_l, gok, stop;
   logic [3:0] fault_v;
   always_ff @(posedge clk_100mhz or negedge rst_n)
      if (!rst_n) begin
         pwm_s1 <= 8'd0;
         req    <= 8'd0;
         est_s1 <= 1'b1;
         est    <= 1'b1;
         est_l  <= 1'b0;
         gok    <= 1'b0;
      end else begin
         pwm_s1 <= bus.pwm_in;
         req    <= pwm_s1;
         est_s1 <= bus.estop_n;
         est    <= est_s1;
         est_l  <= ~est | (est_l & ~bus.fault_clr);
         gok    <= ~est_l & ~|fault_v;
      end
   // stop takes effect in the same cycle est falls, before the latch itself updates
   assign stop = ~est | est_l;
   genvar k;
   for (k = 0; k < 4; k++) begin : g_leg
      state_t     st, nx, idle_nx;
      logic [7:0] cnt, cnt_nx;
      logic [1:0] r;
      logic       hi, lo;
      assign r = req[2*k +: 2];
      always_comb begin
         idle_nx = (r == 2'b01) ? HI : (r == 2'b10) ? LO : (r == 2'b11) ? FAULT : IDLE;
         nx      = st;
         cnt_nx  = 8'd0;
         if (st == FAULT) nx = (bus.fault_clr && r == 2'b00) ? IDLE : FAULT;
         else if (stop) nx = IDLE;
         else begin
            case (st)
               HI:      nx = (r == 2'b01) ? HI : (r == 2'b11) ? FAULT : DEAD;
               LO:      nx = (r == 2'b10) ? LO : (r == 2'b11) ? FAULT : DEAD;
               DEAD:    nx = (cnt != 8'd0) ? DEAD : idle_nx;
               default: nx = idle_nx;
            endcase
            cnt_nx = (st == DEAD) ? ((cnt != 8'd0) ? cnt - 8'd1 : 8'd0) : (nx == DEAD) ? DT_LD : 8'd0;
         end
      end
      always_ff @(posedge clk_100mhz or negedge rst_n)
         if (!rst_n) begin
            st  <= IDLE;
            cnt <= 8'd0;
            hi  <= 1'b0;
            lo  <= 1'b0;
         end else begin
            st  <= nx;
            cnt <= cnt_nx;
            hi  <= nx == HI;
            lo  <= nx == LO;
         end
      assign gate_q[2*k]   = hi;
      assign gate_q[2*k+1] = lo;
      assign fault_v[k]    = st == FAULT;
   end
   assign bus.gate_out      = gate_q;
   assign bus.leg_fault     = fault_v;
   assign bus.estop_latched = est_l;
   assign bus.gate_ok       = gok;
endmodule

// File: tb/tb_pwm_gate_guard.sv
// tb_pwm_gate_guard: directed scoreboard bench for pwm_gate_guard with DT_MIN = 50
module tb_pwm_gate_guard;
   typedef struct {
      string      tag;
      logic [7:0] g;
      logic [3:0] f;
      logic       e;
      logic       ok;
   } exp_t;
   exp_t sb[$];
   logic clk_100mhz = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passed = 0;
   pwm_gate_guard_if bus ();
   pwm_gate_guard #(.DT_MIN(50)) dut (.clk_100mhz(clk_100mhz), .rst_n(rst_n), .bus(bus));
   always #5 clk_100mhz = ~clk_100mhz;
   task automatic tick(input int n);
      repeat (n) @(posedge clk_100mhz);
      #1;
   endtask
   task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
   endtask
   task automatic check();
      exp_t x;
      x = sb.pop_front();
      cmp(x.tag, "gate_out", bus.gate_out, x.g);
      cmp(x.tag, "leg_fault", {4'd0, bus.leg_fault}, {4'd0, x.f});
      cmp(x.tag, "estop_latched", {7'd0, bus.estop_latched}, {7'd0, x.e});
      cmp(x.tag, "gate_ok", {7'd0, bus.gate_ok}, {7'd0, x.ok});
   endtask
   task automatic step(input int n, input string tag, input logic [7:0] g, input logic [3:0] f, input logic e, input logic ok);
      sb.push_back('{tag, g, f, e, ok});
      tick(n);
      check();
   endtask
   task automatic pulse_clr();
      bus.fault_clr = 1'b1;
      tick(1);
      bus.fault_clr = 1'b0;
   endtask
   initial begin
      bus.pwm_in    = 8'hFF;
      bus.estop_n   = 1'b0;
      bus.fault_clr = 1'b0;
      step(3, "reset_hold", 8'h00, 4'h0, 1'b0, 1'b0);
      bus.pwm_in  = 8'h00;
      bus.estop_n = 1'b1;
      tick(1);
      rst_n = 1'b1;
      step(1, "reset_release", 8'h00, 4'h0, 1'b0, 1'b1);
      bus.pwm_in = 8'h01;
      step(2, "hi_latency2", 8'h00, 4'h0, 1'b0, 1'b1);
      step(1, "hi_latency3", 8'h01, 4'h0, 1'b0, 1'b1);
      bus.pwm_in = 8'h02;
      step(3, "dead_first", 8'h00, 4'h0, 1'b0, 1'b1);
      step(49, "dead_last", 8'h00, 4'h0, 1'b0, 1'b1);
      step(1, "lo_on", 8'h02, 4'h0, 1'b0, 1'b1);
      bus.pwm_in = 8'h00;
      step(60, "settle_idle", 8'h00, 4'h0, 1'b0, 1'b1);
      bus.pwm_in = 8'h0D;
      step(2, "shoot_pre", 8'h00, 4'h0, 1'b0, 1'b1);
      step(1, "shoot_fault", 8'h01, 4'h2, 1'b0, 1'b1);
      step(1, "shoot_gate_ok", 8'h01, 4'h2, 1'b0, 1'b0);
      pulse_clr();
      step(1, "clr_ignored", 8'h01, 4'h2, 1'b0, 1'b0);
      bus.pwm_in = 8'h01;
      tick(2);
      bus.fault_clr = 1'b1;
      step(1, "clr_fault", 8'h01, 4'h0, 1'b0, 1'b0);
      bus.fault_clr = 1'b0;
      step(1, "clr_gate_ok", 8'h01, 4'h0, 1'b0, 1'b1);
      bus.pwm_in = 8'h55;
      step(5, "all_high", 8'h55, 4'h0, 1'b0, 1'b1);
      bus.estop_n = 1'b0;
      step(2, "estop_pre", 8'h55, 4'h0, 1'b0, 1'b1);
      step(1, "estop_hit", 8'h00, 4'h0, 1'b1, 1'b1);
      step(1, "estop_gate_ok", 8'h00, 4'h0, 1'b1, 1'b0);
      bus.estop_n = 1'b1;
      step(5, "estop_held", 8'h00, 4'h0, 1'b1, 1'b0);
      bus.fault_clr = 1'b1;
      step(1, "estop_clr", 8'h00, 4'h0, 1'b0, 1'b0);
      bus.fault_clr = 1'b0;
      step(1, "estop_resume", 8'h55, 4'h0, 1'b0, 1'b1);
      bus.estop_n = 1'b0;
      tick(2);
      bus.fault_clr = 1'b1;
      step(1, "simul_stop_wins", 8'h00, 4'h0, 1'b1, 1'b1);
      bus.fault_clr = 1'b0;
      step(1, "simul_latched", 8'h00, 4'h0, 1'b1, 1'b0);
      bus.estop_n = 1'b1;
      tick(3);
      bus.fault_clr = 1'b1;
      step(1, "simul_clr", 8'h00, 4'h0, 1'b0, 1'b0);
      bus.fault_clr = 1'b0;
      step(1, "simul_resume", 8'h55, 4'h0, 1'b0, 1'b1);
      bus.pwm_in = 8'h54;
      step(2, "reassert_pre", 8'h55, 4'h0, 1'b0, 1'b1);
      bus.pwm_in = 8'h55;
      step(1, "reassert_off", 8'h54, 4'h0, 1'b0, 1'b1);
      step(49, "reassert_dead_last", 8'h54, 4'h0, 1'b0, 1'b1);
      step(1, "reassert_on", 8'h55, 4'h0, 1'b0, 1'b1);
      sb.push_back('{"async_reset", 8'h00, 4'h0, 1'b0, 1'b0});
      rst_n = 1'b0;
      #2;
      check();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
